// File: rtl/exec_muldiv_stage_if.sv
// Execute-stage bundle: instruction/operand inputs from the pipeline and stage results.
interface exec_muldiv_stage_if #(
    parameter int XLEN     = 32,
    parameter int FWD_SRCS = 2
);
    localparam int FSW = $clog2(FWD_SRCS + 1);

    logic                     ex_valid;
    logic                     flush;
    logic [XLEN-1:0]          pc;
    logic [XLEN-1:0]          rrd1;
    logic [XLEN-1:0]          rrd2;
    logic [XLEN-1:0]          imm;
    logic [FWD_SRCS*XLEN-1:0] fwd_data;
    logic [FSW-1:0]           forward_rrd1;
    logic [FSW-1:0]           forward_rrd2;
    logic [1:0]               alu_srca;
    logic                     alu_srcb;
    logic [3:0]               alu_op;
    logic [2:0]               bj_op;
    logic                     md_en;
    logic [2:0]               md_op;
    logic [XLEN-1:0]          result;
    logic                     result_valid;
    logic                     b_taken;
    logic                     ex_stall;

    modport master (
        output ex_valid, flush, pc, rrd1, rrd2, imm, fwd_data, forward_rrd1, forward_rrd2,
               alu_srca, alu_srcb, alu_op, bj_op, md_en, md_op,
        input  result, result_valid, b_taken, ex_stall
    );

    modport slave (
        input  ex_valid, flush, pc, rrd1, rrd2, imm, fwd_data, forward_rrd1, forward_rrd2,
               alu_srca, alu_srcb, alu_op, bj_op, md_en, md_op,
        output result, result_valid, b_taken, ex_stall
    );
endinterface

// File: rtl/exec_muldiv_stage.sv
// Execute stage: operand forwarding, ALU, branch compare and an iterative
// radix-2 multiply/divide unit that stalls the pipeline while it runs.
module exec_muldiv_stage #(
    parameter int XLEN     = 32,
    parameter int FWD_SRCS = 2
) (
    input  logic               clk,
    input  logic               reset,
    exec_muldiv_stage_if.slave ex
);
    localparam int FSW  = $clog2(FWD_SRCS + 1);
    localparam int SHW  = $clog2(XLEN);
    localparam int CNTW = $clog2(XLEN + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [2:0] MD_MUL    = 3'd0;
    localparam logic [2:0] MD_MULH   = 3'd1;
    localparam logic [2:0] MD_MULHSU = 3'd2;
    localparam logic [2:0] MD_MULHU  = 3'd3;
    localparam logic [2:0] MD_DIV    = 3'd4;
    localparam logic [2:0] MD_DIVU   = 3'd5;
    localparam logic [2:0] MD_REM    = 3'd6;
    localparam logic [2:0] MD_REMU   = 3'd7;

    // Two's-complement negate when requested; used for sign correction.
    function automatic logic [XLEN-1:0] cond_neg(input logic neg, input logic [XLEN-1:0] v);
        return neg ? -v : v;
    endfunction

    logic [XLEN-1:0]   rs1_s;
    logic [XLEN-1:0]   rs2_s;
    logic [XLEN-1:0]   srca_s;
    logic [XLEN-1:0]   srcb_s;
    logic [XLEN-1:0]   alu_s;
    logic [SHW-1:0]    shamt_s;
    logic              cond_s;

    logic [1:0]        state_r;
    logic [CNTW-1:0]   cnt_r;
    logic [2:0]        op_r;
    logic [XLEN-1:0]   hi_r;     // product high half / partial remainder
    logic [XLEN-1:0]   lo_r;     // multiplier bits / quotient bits
    logic [XLEN-1:0]   mag_r;    // multiplicand or divisor magnitude
    logic [XLEN-1:0]   rs1_r;    // raw dividend, returned as remainder on divide by zero
    logic              a_neg_r;
    logic              b_neg_r;
    logic              div0_r;

    logic              accept_s;
    logic              a_sgn_s;
    logic              b_sgn_s;
    logic              a_neg_s;
    logic              b_neg_s;
    logic [XLEN-1:0]   abs_a_s;
    logic [XLEN-1:0]   abs_b_s;

    logic [XLEN:0]     mul_sum_s;
    logic [XLEN:0]     div_diff_s;
    logic              div_ok_s;
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   quot_s;
    logic [XLEN-1:0]   rem_s;
    logic [XLEN-1:0]   md_res_s;

    logic [XLEN-1:0]   result_s;
    logic              result_valid_s;
    logic              b_taken_s;
    logic              ex_stall_s;

    // Pick register operands from the forwarding network or the register file.
    always_comb begin
        rs1_s = ex.rrd1;
        rs2_s = ex.rrd2;
        for (int k = 1; k <= FWD_SRCS; k++) begin
            rs1_s = (ex.forward_rrd1 == FSW'(k)) ? ex.fwd_data[(k-1)*XLEN +: XLEN] : rs1_s;
            rs2_s = (ex.forward_rrd2 == FSW'(k)) ? ex.fwd_data[(k-1)*XLEN +: XLEN] : rs2_s;
        end
    end

    // Select ALU source operands.
    always_comb begin
        case (ex.alu_srca)
            2'd0:    srca_s = rs1_s;
            2'd2:    srca_s = ex.pc;
            default: srca_s = {XLEN{1'b0}};
        endcase
        if (ex.alu_srcb) begin
            srcb_s = ex.imm;
        end else begin
            srcb_s = rs2_s;
        end
        shamt_s = srcb_s[SHW-1:0];
    end

    // Single-cycle ALU.
    always_comb begin
        case (ex.alu_op)
            4'd0:    alu_s = srca_s + srcb_s;
            4'd1:    alu_s = srca_s - srcb_s;
            4'd2:    alu_s = srca_s << shamt_s;
            4'd3:    alu_s = {{(XLEN-1){1'b0}}, ($signed(srca_s) < $signed(srcb_s))};
            4'd4:    alu_s = {{(XLEN-1){1'b0}}, (srca_s < srcb_s)};
            4'd5:    alu_s = srca_s ^ srcb_s;
            4'd6:    alu_s = srca_s >> shamt_s;
            4'd7:    alu_s = $signed(srca_s) >>> shamt_s;
            4'd8:    alu_s = srca_s | srcb_s;
            4'd9:    alu_s = srca_s & srcb_s;
            4'd10:   alu_s = srcb_s;
            default: alu_s = {XLEN{1'b0}};
        endcase
    end

    // Branch / jump condition on the ALU sources.
    always_comb begin
        case (ex.bj_op)
            3'd1:    cond_s = (srca_s == srcb_s);
            3'd2:    cond_s = (srca_s != srcb_s);
            3'd3:    cond_s = ($signed(srca_s) < $signed(srcb_s));
            3'd4:    cond_s = ($signed(srca_s) >= $signed(srcb_s));
            3'd5:    cond_s = (srca_s < srcb_s);
            3'd6:    cond_s = (srca_s >= srcb_s);
            3'd7:    cond_s = 1'b1;
            default: cond_s = 1'b0;
        endcase
    end

    // Operand signedness and magnitudes captured when an M op is accepted.
    always_comb begin
        case (ex.md_op)
            MD_MUL, MD_MULH, MD_DIV, MD_REM: begin
                a_sgn_s = 1'b1;
                b_sgn_s = 1'b1;
            end
            MD_MULHSU: begin
                a_sgn_s = 1'b1;
                b_sgn_s = 1'b0;
            end
            default: begin
                a_sgn_s = 1'b0;
                b_sgn_s = 1'b0;
            end
        endcase
        a_neg_s  = a_sgn_s & rs1_s[XLEN-1];
        b_neg_s  = b_sgn_s & rs2_s[XLEN-1];
        abs_a_s  = cond_neg(a_neg_s, rs1_s);
        abs_b_s  = cond_neg(b_neg_s, rs2_s);
        accept_s = (state_r == ST_IDLE) & ex.ex_valid & ex.md_en & ~ex.flush;
    end

    // One radix-2 step: shift-add multiply and restoring divide candidates.
    always_comb begin
        mul_sum_s  = {1'b0, hi_r} + (lo_r[0] ? {1'b0, mag_r} : {(XLEN+1){1'b0}});
        div_diff_s = {hi_r, lo_r[XLEN-1]} - {1'b0, mag_r};
        div_ok_s   = ~div_diff_s[XLEN];
    end

    // Final sign correction and special divide cases.
    always_comb begin
        prod_s = (a_neg_r ^ b_neg_r) ? -{hi_r, lo_r} : {hi_r, lo_r};
        if (div0_r) begin
            quot_s = {XLEN{1'b1}};
            rem_s  = rs1_r;
        end else begin
            quot_s = cond_neg(a_neg_r ^ b_neg_r, lo_r);
            rem_s  = cond_neg(a_neg_r, hi_r);
        end
        case (op_r)
            MD_MUL:                       md_res_s = prod_s[XLEN-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU: md_res_s = prod_s[2*XLEN-1:XLEN];
            MD_DIV, MD_DIVU:              md_res_s = quot_s;
            MD_REM, MD_REMU:              md_res_s = rem_s;
            default:                      md_res_s = {XLEN{1'b0}};
        endcase
    end

    // Multiply/divide sequencer and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            cnt_r   <= {CNTW{1'b0}};
            op_r    <= 3'd0;
            hi_r    <= {XLEN{1'b0}};
            lo_r    <= {XLEN{1'b0}};
            mag_r   <= {XLEN{1'b0}};
            rs1_r   <= {XLEN{1'b0}};
            a_neg_r <= 1'b0;
            b_neg_r <= 1'b0;
            div0_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        state_r <= ST_BUSY;
                        cnt_r   <= CNTW'(XLEN);
                        op_r    <= ex.md_op;
                        hi_r    <= {XLEN{1'b0}};
                        lo_r    <= ex.md_op[2] ? abs_a_s : abs_b_s;
                        mag_r   <= ex.md_op[2] ? abs_b_s : abs_a_s;
                        rs1_r   <= rs1_s;
                        a_neg_r <= a_neg_s;
                        b_neg_r <= b_neg_s;
                        div0_r  <= (rs2_s == {XLEN{1'b0}});
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    if (ex.flush) begin
                        state_r <= ST_IDLE;
                        cnt_r   <= {CNTW{1'b0}};
                    end else begin
                        if (op_r[2]) begin
                            hi_r <= div_ok_s ? div_diff_s[XLEN-1:0] : {hi_r[XLEN-2:0], lo_r[XLEN-1]};
                            lo_r <= {lo_r[XLEN-2:0], div_ok_s};
                        end else begin
                            hi_r <= mul_sum_s[XLEN:1];
                            lo_r <= {mul_sum_s[0], lo_r[XLEN-1:1]};
                        end
                        cnt_r   <= cnt_r - CNTW'(1);
                        state_r <= (cnt_r == CNTW'(1)) ? ST_DONE : ST_BUSY;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= {CNTW{1'b0}};
                end
            endcase
        end
    end

    // Stage outputs; reset forces them all low.
    always_comb begin
        if (reset) begin
            result_s       = {XLEN{1'b0}};
            result_valid_s = 1'b0;
            b_taken_s      = 1'b0;
            ex_stall_s     = 1'b0;
        end else begin
            result_s       = (state_r == ST_DONE) ? md_res_s : alu_s;
            if (state_r == ST_DONE) begin
                result_valid_s = ~ex.flush;
            end else begin
                result_valid_s = (state_r == ST_IDLE) & ex.ex_valid & ~ex.md_en & ~ex.flush;
            end
            b_taken_s      = ex.ex_valid & ~ex.md_en & ~ex.flush & cond_s;
            ex_stall_s     = accept_s | ((state_r == ST_BUSY) & ~ex.flush);
        end
    end

    assign ex.result       = result_s;
    assign ex.result_valid = result_valid_s;
    assign ex.b_taken      = b_taken_s;
    assign ex.ex_stall     = ex_stall_s;
endmodule

// File: doc/exec_muldiv_stage.md
EXEC_MULDIV_STAGE -- requirements
Module: exec_muldiv_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning datapath width (power of two, >= 8).
REQ-002 SHALL have parameter FWD_SRCS, default 2, meaning number of forwarding data sources; FSW = clog2(FWD_SRCS+1).
REQ-003 SHALL have port clk  in  1  meaning the single clock; all state on rising edge.
REQ-004 SHALL have port reset  in  1  meaning synchronous, active-high reset.
REQ-005 SHALL have ports ex_valid in 1 (valid instruction in EX) and flush in 1 (kill the EX instruction).
REQ-006 SHALL have ports pc, rrd1, rrd2, imm, each in XLEN, meaning the PC, register read data and immediate.
REQ-007 SHALL have port fwd_data  in  FWD_SRCS*XLEN  meaning forwarding sources; slice k-1 is source k.
REQ-008 SHALL have ports forward_rrd1, forward_rrd2, each in FSW: 0 = no forward, k = fwd_data source k; values > FWD_SRCS = no forward.
REQ-009 SHALL have ports alu_srca in 2 (0 rs1, 1 zero, 2 pc, 3 zero), alu_srcb in 1 (0 rs2, 1 imm), alu_op in 4, bj_op in 3.
REQ-010 SHALL have ports md_en in 1 (M-extension op) and md_op in 3 (0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU).
REQ-011 SHALL have outputs result out XLEN, result_valid out 1, b_taken out 1 and ex_stall out 1.

Function
REQ-012 Operands: rs1/rs2 SHALL be selected by forward_rrd1/2, then srca/srcb by alu_srca/alu_srcb, combinationally.
REQ-013 alu_op: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASS-B; others give 0; shift amount = srcb[clog2(XLEN)-1:0]; arithmetic modulo 2^XLEN.
REQ-014 bj_op: 0 none, 1 EQ, 2 NE, 3 LT, 4 GE, 5 LTU, 6 GEU, 7 always, comparing srca with srcb; b_taken SHALL be 1 only when ex_valid=1, md_en=0, flush=0 and the condition holds.
REQ-015 Non-MD path: when md_en=0, result = ALU output and result_valid = ex_valid & ~flush, same cycle, no stall.
REQ-016 MD unit FSM states: IDLE, BUSY, DONE.
REQ-017 IDLE->BUSY when ex_valid & md_en & ~flush: rs1/rs2 (forwarded, not srca/srcb) and md_op SHALL be registered; iteration counter loaded with XLEN.
REQ-018 BUSY SHALL perform one radix-2 step per cycle (shift-add multiply on sign-corrected magnitudes; restoring divide), decrementing the counter; at counter 1 -> DONE.
REQ-019 DONE SHALL drive result = MD result and result_valid = 1 for exactly one cycle, then -> IDLE.
REQ-020 Latency: result_valid SHALL assert exactly XLEN+1 cycles after the accepting edge of IDLE->BUSY.
REQ-021 ex_stall SHALL equal (IDLE & ex_valid & md_en & ~flush) | BUSY; it is 0 in DONE; upstream holds all inputs while ex_stall=1.
REQ-022 MUL SHALL return the low XLEN product bits; MULH/MULHSU/MULHU the high XLEN bits with signed*signed, signed*unsigned, unsigned*unsigned.
REQ-023 Divide by zero SHALL give quotient all-ones (DIV and DIVU) and remainder = dividend.
REQ-024 Signed overflow (most-negative / -1) SHALL give quotient = dividend, remainder = 0.
REQ-025 Signed DIV quotient sign = sign(rs1) XOR sign(rs2); REM sign = sign(rs1); rounding toward zero.
REQ-026 flush in BUSY or DONE SHALL return FSM to IDLE next edge, with result_valid=0 and ex_stall=0 in that flush cycle.
REQ-027 In BUSY/DONE, ex_valid and operand inputs SHALL be ignored; no new op is accepted until the cycle after DONE.

Reset
REQ-028 While reset=1 SHALL force FSM to IDLE, counter 0, MD operand/accumulator registers 0.
REQ-029 While reset=1 outputs SHALL be result=0, result_valid=0, b_taken=0, ex_stall=0, regardless of other inputs.
REQ-030 Reset asserted mid-operation SHALL abort the operation; no result_valid follows deassertion.

Verification
REQ-031 ADD with forward_rrd1=1, fwd_data[0]=5, rrd2=7, alu_srcb=0 -> result=12, result_valid=1 same cycle, ex_stall=0.
REQ-032 BLT srca=0xFFFFFFFF, srcb=1 -> b_taken=1; BLTU same operands -> b_taken=0; BEQ with md_en=1 -> b_taken=0.
REQ-033 MULH rs1=0x80000000, rs2=0x80000000 -> ex_stall=1 for 33 cycles, result=0x40000000, result_valid=1 at cycle 33 after acceptance.
REQ-034 DIV 7/0 -> 0xFFFFFFFF; REM 7/0 -> 7; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -7/2 -> 0xFFFFFFFF.
REQ-035 DIVU 100/7 started, flush at cycle 10 -> next cycle IDLE, ex_stall=0, no result_valid; next DIVU 100/7 -> 14.
REQ-036 Reset at BUSY cycle 5 -> outputs 0 during reset, FSM IDLE after, no stray result_valid; back-to-back MUL 3*4 then MUL 5*6 -> 12 then 30, each 33 cycles.
